// File: rtl/mem_arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_arb_pkg                                                          |
// | Shared types and default widths for the ic/dc memory arbiter.        |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
package mem_arb_pkg;

    localparam int c_DEFAULT_ADDR_WIDTH   = 32;
    localparam int c_DEFAULT_DATA_WIDTH   = 32;
    localparam int c_DEFAULT_STARVE_LIMIT = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } state_t;

    typedef enum logic {
        OWN_IC = 1'b0,
        OWN_DC = 1'b1
    } owner_t;

    // Counter width able to hold 0..limit inclusive.
    function automatic int cnt_width(input int limit);
        return (limit < 1) ? 1 : $clog2(limit + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_arb_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_arb_if                                                           |
// | Fetch, data and backing-memory buses of the memory arbiter.          |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
interface mem_arb_if
    import mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = c_DEFAULT_ADDR_WIDTH,
    parameter int DATA_WIDTH = c_DEFAULT_DATA_WIDTH
);
    logic                  ic_req_valid;
    logic                  ic_req_ready;
    logic [ADDR_WIDTH-1:0] ic_req_addr;
    logic                  ic_resp_valid;
    logic [DATA_WIDTH-1:0] ic_resp_data;

    logic                  dc_req_valid;
    logic                  dc_req_ready;
    logic                  dc_req_we;
    logic [ADDR_WIDTH-1:0] dc_req_addr;
    logic [DATA_WIDTH-1:0] dc_req_wdata;
    logic                  dc_resp_valid;
    logic [DATA_WIDTH-1:0] dc_resp_data;

    logic                  mem_req_valid;
    logic                  mem_req_ready;
    logic                  mem_req_we;
    logic [ADDR_WIDTH-1:0] mem_req_addr;
    logic [DATA_WIDTH-1:0] mem_req_wdata;
    logic                  mem_resp_valid;
    logic [DATA_WIDTH-1:0] mem_resp_data;

    // Arbiter side.
    modport slave (
        input  ic_req_valid, ic_req_addr,
        output ic_req_ready, ic_resp_valid, ic_resp_data,
        input  dc_req_valid, dc_req_we, dc_req_addr, dc_req_wdata,
        output dc_req_ready, dc_resp_valid, dc_resp_data,
        output mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata,
        input  mem_req_ready, mem_resp_valid, mem_resp_data
    );

    // Requester and memory side.
    modport master (
        output ic_req_valid, ic_req_addr,
        input  ic_req_ready, ic_resp_valid, ic_resp_data,
        output dc_req_valid, dc_req_we, dc_req_addr, dc_req_wdata,
        input  dc_req_ready, dc_resp_valid, dc_resp_data,
        input  mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata,
        output mem_req_ready, mem_resp_valid, mem_resp_data
    );

endinterface
`default_nettype wire

// File: rtl/mem_arb_select.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_arb_select                                                       |
// | dc-priority grant selection with an ic starvation counter.           |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module mem_arb_select
    import mem_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = c_DEFAULT_STARVE_LIMIT
) (
    input  logic clk,
    input  logic reset,
    input  logic ic_valid,
    input  logic dc_valid,
    input  logic grant_en,
    output logic grant_ic,
    output logic grant_dc
);
    localparam int                 c_CNT_W = cnt_width(STARVE_LIMIT);
    localparam logic [c_CNT_W-1:0] c_LIMIT = c_CNT_W'(STARVE_LIMIT);
    localparam logic [c_CNT_W-1:0] c_ONE   = c_CNT_W'(1);

    logic [c_CNT_W-1:0] r_starve_cnt;
    logic               w_force_ic;

    always_comb begin
        w_force_ic = (r_starve_cnt == c_LIMIT);
        grant_ic   = grant_en && ic_valid && (!dc_valid || w_force_ic);
        grant_dc   = grant_en && dc_valid && !grant_ic;
    end

    // Counts dc wins that left a waiting ic behind; any other grant clears it.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_starve_cnt <= '0;
        end else if (grant_dc && ic_valid) begin
            if (!w_force_ic) begin
                r_starve_cnt <= r_starve_cnt + c_ONE;
            end
        end else if (grant_ic || grant_dc) begin
            r_starve_cnt <= '0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_arbiter                                                          |
// | Shares one memory port between fetch (ic) and data (dc) requesters,  |
// | one transaction in flight. Optional macro MEM_ARB_PERF_CNT_EN adds   |
// | grant and wait-cycle performance counters.                           |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH   = c_DEFAULT_ADDR_WIDTH,
    parameter int DATA_WIDTH   = c_DEFAULT_DATA_WIDTH,
    parameter int STARVE_LIMIT = c_DEFAULT_STARVE_LIMIT
) (
    input  logic        clk,
    input  logic        reset,
    mem_arb_if.slave    bus
`ifdef MEM_ARB_PERF_CNT_EN
    ,
    output logic [31:0] perf_ic_grants,
    output logic [31:0] perf_dc_grants,
    output logic [31:0] perf_wait_cycles
`endif
);
    state_t                r_state;
    state_t                w_next_state;
    owner_t                r_owner;
    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [DATA_WIDTH-1:0] r_ic_resp_data;
    logic [DATA_WIDTH-1:0] r_dc_resp_data;

    logic w_grant_en;
    logic w_grant_ic;
    logic w_grant_dc;
    logic w_resp_capture;

    // No grants while reset is held, so every output stays quiet.
    assign w_grant_en     = reset && (r_state == IDLE);
    assign w_resp_capture = (r_state == WAIT) && bus.mem_resp_valid;

    mem_arb_select #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_select (
        .clk      (clk),
        .reset    (reset),
        .ic_valid (bus.ic_req_valid),
        .dc_valid (bus.dc_req_valid),
        .grant_en (w_grant_en),
        .grant_ic (w_grant_ic),
        .grant_dc (w_grant_dc)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state      = r_state;
        bus.ic_req_ready  = w_grant_ic;
        bus.dc_req_ready  = w_grant_dc;
        bus.mem_req_valid = 1'b0;
        bus.mem_req_we    = r_we;
        bus.mem_req_addr  = r_addr;
        bus.mem_req_wdata = r_wdata;
        bus.ic_resp_valid = 1'b0;
        bus.dc_resp_valid = 1'b0;
        bus.ic_resp_data  = r_ic_resp_data;
        bus.dc_resp_data  = r_dc_resp_data;
        case (r_state)
            IDLE: begin
                if (w_grant_ic || w_grant_dc) begin
                    w_next_state = REQ;
                end
            end
            REQ: begin
                bus.mem_req_valid = 1'b1;
                if (bus.mem_req_ready) begin
                    w_next_state = WAIT;
                end
            end
            WAIT: begin
                if (bus.mem_resp_valid) begin
                    w_next_state = RESP;
                end
            end
            RESP: begin
                bus.ic_resp_valid = (r_owner == OWN_IC);
                bus.dc_resp_valid = (r_owner == OWN_DC);
                w_next_state      = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Request payload is captured at grant; response data is kept per
    // requester so each side's data holds between its own pulses.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_owner        <= OWN_DC;
            r_we           <= 1'b0;
            r_addr         <= '0;
            r_wdata        <= '0;
            r_ic_resp_data <= '0;
            r_dc_resp_data <= '0;
        end else begin
            if (w_grant_ic) begin
                r_owner <= OWN_IC;
                r_we    <= 1'b0;
                r_addr  <= bus.ic_req_addr;
                r_wdata <= '0;
            end else if (w_grant_dc) begin
                r_owner <= OWN_DC;
                r_we    <= bus.dc_req_we;
                r_addr  <= bus.dc_req_addr;
                r_wdata <= bus.dc_req_wdata;
            end
            if (w_resp_capture) begin
                if (r_owner == OWN_IC) begin
                    r_ic_resp_data <= bus.mem_resp_data;
                end else begin
                    r_dc_resp_data <= bus.mem_resp_data;
                end
            end
        end
    end

`ifdef MEM_ARB_PERF_CNT_EN
    logic [31:0] r_perf_ic;
    logic [31:0] r_perf_dc;
    logic [31:0] r_perf_wait;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_perf_ic   <= '0;
            r_perf_dc   <= '0;
            r_perf_wait <= '0;
        end else begin
            if (w_grant_ic) begin
                r_perf_ic <= r_perf_ic + 32'd1;
            end
            if (w_grant_dc) begin
                r_perf_dc <= r_perf_dc + 32'd1;
            end
            if ((r_state == REQ) || (r_state == WAIT)) begin
                r_perf_wait <= r_perf_wait + 32'd1;
            end
        end
    end

    assign perf_ic_grants   = r_perf_ic;
    assign perf_dc_grants   = r_perf_dc;
    assign perf_wait_cycles = r_perf_wait;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_mem_arbiter                                                       |
// | Directed scoreboard bench for mem_arbiter with a small memory model. |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int LIM = 4;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    mem_arb_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

`ifdef MEM_ARB_PERF_CNT_EN
    logic [31:0] perf_ic_grants;
    logic [31:0] perf_dc_grants;
    logic [31:0] perf_wait_cycles;
`endif

    mem_arbiter #(
        .ADDR_WIDTH   (AW),
        .DATA_WIDTH   (DW),
        .STARVE_LIMIT (LIM)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .bus              (bus)
`ifdef MEM_ARB_PERF_CNT_EN
        ,
        .perf_ic_grants   (perf_ic_grants),
        .perf_dc_grants   (perf_dc_grants),
        .perf_wait_cycles (perf_wait_cycles)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic          is_ic;
        logic [DW-1:0] data;
    } exp_t;

    exp_t sb[$];

    logic [DW-1:0] mem [logic [AW-1:0]];
    bit            mem_auto   = 1'b0;
    int            stall_cfg  = 0;
    logic          man_ready  = 1'b0;
    logic          man_rv     = 1'b0;
    logic [DW-1:0] man_rd     = '0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] memread(input logic [AW-1:0] a);
        if (mem.exists(a)) return mem[a];
        return a ^ 32'h5A5A_0000;
    endfunction

    // Memory model: stalls stall_cfg cycles per request, answers one cycle
    // after acceptance. When mem_auto is off the manual values are driven.
    initial begin : g_mem_model
        int            cnt;
        logic          prev_v;
        logic          hs;
        logic [DW-1:0] hs_data;
        cnt = 0; prev_v = 1'b0; hs = 1'b0; hs_data = '0;
        mem[32'h0000_000C] = 32'h0320_0093;
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b0;
        bus.mem_resp_data  = '0;
        forever begin
            @(posedge clk);
            #2;
            if (mem_auto) begin
                bus.mem_resp_valid = 1'b0;
                if (hs) begin
                    bus.mem_resp_valid = 1'b1;
                    bus.mem_resp_data  = hs_data;
                    hs = 1'b0;
                end
                bus.mem_req_ready = 1'b0;
                if (bus.mem_req_valid) begin
                    if (!prev_v) cnt = stall_cfg;
                    if (cnt > 0) begin
                        cnt--;
                    end else begin
                        bus.mem_req_ready = 1'b1;
                        hs = 1'b1;
                        if (bus.mem_req_we) begin
                            mem[bus.mem_req_addr] = bus.mem_req_wdata;
                            hs_data = bus.mem_req_wdata;
                        end else begin
                            hs_data = memread(bus.mem_req_addr);
                        end
                    end
                end
                prev_v = bus.mem_req_valid;
            end else begin
                hs = 1'b0;
                prev_v = 1'b0;
                bus.mem_req_ready  = man_ready;
                bus.mem_resp_valid = man_rv;
                bus.mem_resp_data  = man_rd;
            end
        end
    end

    // Response monitor: every pulse must match the oldest expectation.
    always @(negedge clk) begin : g_monitor
        exp_t e;
        if (bus.ic_resp_valid === 1'b1 || bus.dc_resp_valid === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_resp", {bus.ic_resp_valid, bus.dc_resp_valid}, 0);
            end else begin
                e = sb.pop_front();
                chk("resp_owner", {bus.ic_resp_valid, bus.dc_resp_valid}, e.is_ic ? 2'b10 : 2'b01);
                chk("resp_data", e.is_ic ? bus.ic_resp_data : bus.dc_resp_data, e.data);
            end
        end
    end

    initial begin : g_watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            tick();
            @(negedge clk);
            #1;
            n++;
        end
        chk("drain", sb.size(), 0);
    endtask

    task automatic wait_grant(input int budget, output int cyc, output logic [1:0] who);
        cyc = 0;
        who = 2'b00;
        while (cyc < budget) begin
            @(negedge clk);
            if (bus.ic_req_ready || bus.dc_req_ready) begin
                who = {bus.ic_req_ready, bus.dc_req_ready};
                break;
            end
            cyc++;
            tick();
        end
    endtask

    task automatic do_txn(input bit is_ic, input bit we, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wd, input logic [DW-1:0] expd);
        tick();
        if (is_ic) begin
            bus.ic_req_valid = 1'b1;
            bus.ic_req_addr  = addr;
        end else begin
            bus.dc_req_valid = 1'b1;
            bus.dc_req_we    = we;
            bus.dc_req_addr  = addr;
            bus.dc_req_wdata = wd;
        end
        @(negedge clk);
        chk("txn_ready", {bus.ic_req_ready, bus.dc_req_ready}, is_ic ? 2'b10 : 2'b01);
        sb.push_back({is_ic, expd});
        tick();
        bus.ic_req_valid = 1'b0;
        bus.dc_req_valid = 1'b0;
        wait_drain(10);
    endtask

    initial begin : g_main
        int         cyc;
        logic [1:0] who;
        logic [1:0] order [6];
        order = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b01};

        bus.ic_req_valid = 1'b1;
        bus.ic_req_addr  = 32'h0000_0044;
        bus.dc_req_valid = 1'b1;
        bus.dc_req_we    = 1'b1;
        bus.dc_req_addr  = 32'h0000_0088;
        bus.dc_req_wdata = 32'h1111_2222;

        // Reset with both requesters active: nothing may be granted.
        tick();
        @(negedge clk);
        chk("rst_ready", {bus.ic_req_ready, bus.dc_req_ready}, 0);
        chk("rst_mem_valid", bus.mem_req_valid, 0);
        chk("rst_resp_valid", {bus.ic_resp_valid, bus.dc_resp_valid}, 0);
        chk("rst_payload", {bus.mem_req_we, bus.mem_req_addr, bus.mem_req_wdata}, 0);
        chk("rst_resp_data", {bus.ic_resp_data, bus.dc_resp_data}, 0);
        tick();
        bus.ic_req_valid = 1'b0;
        bus.dc_req_valid = 1'b0;
        reset    = 1'b1;
        mem_auto = 1'b1;

        // Single ic read, memory ready at once.
        tick();
        bus.ic_req_valid = 1'b1;
        bus.ic_req_addr  = 32'h0000_000C;
        @(negedge clk);
        chk("t1_ready", {bus.ic_req_ready, bus.dc_req_ready}, 2'b10);
        sb.push_back({1'b1, 32'h0320_0093});
        tick();
        bus.ic_req_valid = 1'b0;
        bus.ic_req_addr  = '0;
        @(negedge clk);
        chk("t1_mem_req", {bus.mem_req_valid, bus.mem_req_we, bus.mem_req_addr}, {1'b1, 1'b0, 32'h0000_000C});
        tick();
        @(negedge clk);
        chk("t1_wait", {bus.mem_req_valid, bus.ic_resp_valid}, 0);
        tick();
        @(negedge clk);
        chk("t1_resp_pulse", bus.ic_resp_valid, 1);
        tick();
        @(negedge clk);
        chk("t1_resp_end", bus.ic_resp_valid, 0);
        chk("t1_data_hold", bus.ic_resp_data, 32'h0320_0093);

        // dc store, memory not ready for three cycles.
        stall_cfg = 3;
        tick();
        bus.dc_req_valid = 1'b1;
        bus.dc_req_we    = 1'b1;
        bus.dc_req_addr  = 32'h0000_0100;
        bus.dc_req_wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("t2_ready", {bus.ic_req_ready, bus.dc_req_ready}, 2'b01);
        sb.push_back({1'b0, 32'hDEAD_BEEF});
        tick();
        bus.dc_req_valid = 1'b0;
        bus.dc_req_addr  = '0;
        bus.dc_req_wdata = '0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t2_req_hold", {bus.mem_req_valid, bus.mem_req_we, bus.mem_req_addr, bus.mem_req_wdata},
                {1'b1, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF});
            tick();
        end
        @(negedge clk);
        chk("t2_req_drop", bus.mem_req_valid, 0);
        #1;
        wait_drain(8);
        stall_cfg = 0;

        // Simultaneous requests: dc first, ic at the next IDLE.
        tick();
        bus.ic_req_valid = 1'b1;
        bus.ic_req_addr  = 32'h0000_0040;
        bus.dc_req_valid = 1'b1;
        bus.dc_req_we    = 1'b0;
        bus.dc_req_addr  = 32'h0000_0200;
        @(negedge clk);
        chk("t3_dc_first", {bus.ic_req_ready, bus.dc_req_ready}, 2'b01);
        sb.push_back({1'b0, memread(32'h0000_0200)});
        tick();
        bus.dc_req_valid = 1'b0;
        wait_grant(10, cyc, who);
        chk("t3_ic_next", who, 2'b10);
        chk("t3_ic_latency", cyc, 3);
        sb.push_back({1'b1, memread(32'h0000_0040)});
        tick();
        bus.ic_req_valid = 1'b0;
        wait_drain(12);

        // Both requesters continuously valid: ic forced in after LIM dc wins.
        tick();
        bus.ic_req_valid = 1'b1;
        bus.ic_req_addr  = 32'h0000_0080;
        bus.dc_req_valid = 1'b1;
        bus.dc_req_we    = 1'b0;
        bus.dc_req_addr  = 32'h0000_0300;
        for (int g = 0; g < 6; g++) begin
            wait_grant(12, cyc, who);
            chk($sformatf("t4_grant_%0d", g), who, order[g]);
            if (who == 2'b10) sb.push_back({1'b1, memread(32'h0000_0080)});
            else if (who == 2'b01) sb.push_back({1'b0, memread(32'h0000_0300)});
            tick();
        end
        bus.ic_req_valid = 1'b0;
        bus.dc_req_valid = 1'b0;
        wait_drain(12);

        // Reset while in WAIT, then a stray memory response.
        tick();
        mem_auto  = 1'b0;
        man_ready = 1'b0;
        man_rv    = 1'b0;
        tick();
        bus.ic_req_valid = 1'b1;
        bus.ic_req_addr  = 32'h0000_0020;
        @(negedge clk);
        chk("t5_grant", bus.ic_req_ready, 1);
        tick();
        bus.ic_req_valid = 1'b0;
        man_ready = 1'b1;
        @(negedge clk);
        chk("t5_req", {bus.mem_req_valid, bus.mem_req_addr}, {1'b1, 32'h0000_0020});
        tick();
        man_ready = 1'b0;
        reset     = 1'b0;
        @(negedge clk);
        chk("t5_wait", bus.mem_req_valid, 0);
        tick();
        @(negedge clk);
        chk("t5_rst_ctrl", {bus.ic_req_ready, bus.dc_req_ready, bus.mem_req_valid,
                            bus.ic_resp_valid, bus.dc_resp_valid}, 0);
        chk("t5_rst_payload", {bus.mem_req_we, bus.mem_req_addr, bus.mem_req_wdata}, 0);
        chk("t5_rst_resp_data", {bus.ic_resp_data, bus.dc_resp_data}, 0);
`ifdef MEM_ARB_PERF_CNT_EN
        chk("t5_perf_clear", {perf_ic_grants, perf_dc_grants, perf_wait_cycles}, 0);
`endif
        tick();
        reset  = 1'b1;
        man_rv = 1'b1;
        man_rd = 32'hBAD0_BAD0;
        @(negedge clk);
        chk("t5_stray", {bus.ic_resp_valid, bus.dc_resp_valid, bus.mem_req_valid}, 0);
        tick();
        man_rv = 1'b0;
        @(negedge clk);
        chk("t5_stray_after", {bus.ic_resp_valid, bus.dc_resp_valid, bus.mem_req_valid}, 0);
        tick();
        @(negedge clk);
        chk("t5_stray_late", {bus.ic_resp_valid, bus.dc_resp_valid}, 0);
        #1;
        mem_auto = 1'b1;

        // Mixed sequence: 3 ic reads and 2 dc accesses.
        do_txn(1'b1, 1'b0, 32'h0000_0000, '0, 32'h5A5A_0000);
        do_txn(1'b0, 1'b1, 32'h0000_0104, 32'h1234_5678, 32'h1234_5678);
        do_txn(1'b1, 1'b0, 32'h0000_0008, '0, 32'h5A5A_0008);
        do_txn(1'b0, 1'b0, 32'h0000_0104, '0, 32'h1234_5678);
        do_txn(1'b1, 1'b0, 32'h0000_000C, '0, 32'h0320_0093);
`ifdef MEM_ARB_PERF_CNT_EN
        chk("perf_ic_grants", perf_ic_grants, 3);
        chk("perf_dc_grants", perf_dc_grants, 2);
        chk("perf_wait_cycles", perf_wait_cycles, 10);
`endif

        tick();
        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
